// File: rtl/fifo_width_packer.sv
// Packs RATIO narrow words popped from a FWFT FIFO into one wide valid/ready beat,
// with packet framing (out_last every PKT_BEATS beats) and a flush that emits a partial beat.
module fifo_width_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int RATIO      = 4,
  parameter int PKT_BEATS  = 16
) (
  input  logic                          clk_read,
  input  logic                          rst_n,
  input  logic                          fifo_empty,
  input  logic [DATA_WIDTH-1:0]         fifo_data,
  output logic                          fifo_read,
  input  logic                          flush,
  output logic [DATA_WIDTH*RATIO-1:0]   out_data,
  output logic [RATIO-1:0]              out_keep,
  output logic                          out_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(RATIO):0]        lane_cnt
);

  localparam int LW = $clog2(RATIO) + 1;
  localparam int CW = $clog2(PKT_BEATS + 1);
  localparam int BW = DATA_WIDTH * RATIO;

  typedef enum logic {
    S_FILL  = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_acc [RATIO-1];
  logic [LW-1:0]         r_lane_cnt;
  logic [CW-1:0]         r_beat_cnt;
  logic                  r_flush_pend;
  logic [BW-1:0]         r_out_data;
  logic [RATIO-1:0]      r_out_keep;
  logic                  r_out_last;
  logic                  r_out_valid;

  logic                  w_out_free;
  logic                  w_pop;
  logic                  w_full_load;
  logic                  w_flush_req;
  logic                  w_pkt_end;
  logic [BW-1:0]         w_full_data;
  logic [BW-1:0]         w_flush_data;
  logic [RATIO-1:0]      w_flush_keep;

  assign w_out_free  = !r_out_valid || out_ready;
  // The last lane only needs the output register, so only it waits for out_free.
  assign w_pop       = !fifo_empty && (r_state == S_FILL) &&
                       ((r_lane_cnt < LW'(RATIO - 1)) || w_out_free);
  assign w_full_load = w_pop && (r_lane_cnt == LW'(RATIO - 1));
  assign w_flush_req = flush || r_flush_pend;
  assign w_pkt_end   = (r_beat_cnt == CW'(PKT_BEATS - 1));

  genvar gi;
  generate
    for (gi = 0; gi < RATIO - 1; gi++) begin : g_lane
      assign w_full_data[gi*DATA_WIDTH +: DATA_WIDTH]  = r_acc[gi];
      assign w_flush_keep[gi]                          = LW'(gi) < r_lane_cnt;
      assign w_flush_data[gi*DATA_WIDTH +: DATA_WIDTH] =
        w_flush_keep[gi] ? r_acc[gi] : '0;
    end
  endgenerate

  assign w_full_data[BW-1 -: DATA_WIDTH]  = fifo_data;
  assign w_flush_data[BW-1 -: DATA_WIDTH] = '0;
  assign w_flush_keep[RATIO-1]            = 1'b0;

  always_ff @(posedge clk_read or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RATIO - 1; i++) r_acc[i] <= '0;
    end else begin
      for (int i = 0; i < RATIO - 1; i++) begin
        if (w_pop && (r_lane_cnt == LW'(i))) r_acc[i] <= fifo_data;
      end
    end
  end

  always_ff @(posedge clk_read or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_FILL;
      r_lane_cnt   <= '0;
      r_beat_cnt   <= '0;
      r_flush_pend <= 1'b0;
      r_out_data   <= '0;
      r_out_keep   <= '0;
      r_out_last   <= 1'b0;
      r_out_valid  <= 1'b0;
    end else begin
      if (w_pop && !w_full_load) r_lane_cnt <= r_lane_cnt + 1'b1;
      if (flush) r_flush_pend <= 1'b1;
      if (r_out_valid && out_ready) r_out_valid <= 1'b0;

      case (r_state)
        S_FILL: begin
          if (w_full_load) begin
            r_out_data  <= w_full_data;
            r_out_keep  <= '1;
            r_out_valid <= 1'b1;
            r_lane_cnt  <= '0;
            // A flush arriving with the completing word closes the packet on this beat.
            if (w_flush_req) begin
              r_out_last   <= 1'b1;
              r_beat_cnt   <= '0;
              r_flush_pend <= 1'b0;
            end else if (w_pkt_end) begin
              r_out_last <= 1'b1;
              r_beat_cnt <= '0;
            end else begin
              r_out_last <= 1'b0;
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
          end else if (r_flush_pend) begin
            if (r_lane_cnt == '0) begin
              if (!w_pop) begin
                r_beat_cnt   <= '0;
                r_flush_pend <= 1'b0;
              end
            end else begin
              r_state <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          if (w_out_free) begin
            r_out_data   <= w_flush_data;
            r_out_keep   <= w_flush_keep;
            r_out_last   <= 1'b1;
            r_out_valid  <= 1'b1;
            r_lane_cnt   <= '0;
            r_beat_cnt   <= '0;
            r_flush_pend <= 1'b0;
            r_state      <= S_FILL;
          end
        end
        default: r_state <= S_FILL;
      endcase
    end
  end

  assign fifo_read = w_pop;
  assign out_data  = r_out_data;
  assign out_keep  = r_out_keep;
  assign out_last  = r_out_last;
  assign out_valid = r_out_valid;
  assign lane_cnt  = r_lane_cnt;

endmodule

// File: tb/tb_fifo_width_packer.sv
// Directed bench for fifo_width_packer (DW=8, RATIO=4, PKT_BEATS=2) with a FWFT FIFO model
// and a beat logger; each scenario task checks its own expected values inline.
module tb_fifo_width_packer;

  logic        clk_read = 1'b0;
  logic        rst_n = 1'b0;
  logic        fifo_empty;
  logic [7:0]  fifo_data;
  logic        fifo_read;
  logic        flush = 1'b0;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_last;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [2:0]  lane_cnt;

  int total = 0;
  int bad = 0;

  logic [7:0] mem [0:63];
  logic [5:0] rd_ptr = '0;
  logic [5:0] wr_ptr = '0;
  int         pop_cnt = 0;
  int         bad_read = 0;

  logic [31:0] log_data [0:127];
  logic [3:0]  log_keep [0:127];
  logic        log_last [0:127];
  int          beat_n = 0;

  fifo_width_packer #(
    .DATA_WIDTH(8),
    .RATIO(4),
    .PKT_BEATS(2)
  ) dut (
    .clk_read  (clk_read),
    .rst_n     (rst_n),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_read (fifo_read),
    .flush     (flush),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .lane_cnt  (lane_cnt)
  );

  always #5 clk_read = ~clk_read;

  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_data  = mem[rd_ptr];

  always @(posedge clk_read) begin
    if (rst_n && fifo_read) begin
      if (fifo_empty) begin
        bad_read <= bad_read + 1;
      end else begin
        rd_ptr  <= rd_ptr + 6'd1;
        pop_cnt <= pop_cnt + 1;
      end
    end
  end

  always @(posedge clk_read) begin
    if (rst_n && out_valid && out_ready) begin
      log_data[beat_n] <= out_data;
      log_keep[beat_n] <= out_keep;
      log_last[beat_n] <= out_last;
      beat_n <= beat_n + 1;
      $display("beat %0d data=%h keep=%b last=%b", beat_n, out_data, out_keep, out_last);
    end
  end

  task automatic push(input logic [7:0] v);
    mem[wr_ptr] = v;
    wr_ptr = wr_ptr + 6'd1;
  endtask

  task automatic wait_beats(input int target, input int budget);
    int k;
    k = 0;
    while (beat_n < target && k < budget) begin
      @(negedge clk_read);
      k++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk_read);
    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk_read);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_data: got %h want 0", out_data); end
    total++; if (out_keep !== 4'h0) begin bad++; $display("FAIL reset_keep: got %b want 0", out_keep); end
    total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_last: got %b want 0", out_last); end
    total++; if (lane_cnt !== 3'd0) begin bad++; $display("FAIL reset_lane: got %0d want 0", lane_cnt); end
    total++; if (fifo_read !== 1'b0) begin bad++; $display("FAIL reset_read: got %b want 0", fifo_read); end
    @(negedge clk_read);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int base, p0;
    @(negedge clk_read);
    out_ready = 1'b1;
    base = beat_n;
    p0 = pop_cnt;
    for (int i = 1; i <= 8; i++) push(8'(i));
    repeat (8) @(negedge clk_read);
    total++; if (pop_cnt - p0 !== 8) begin bad++; $display("FAIL basic_pops: got %0d want 8", pop_cnt - p0); end
    wait_beats(base + 2, 20);
    total++; if (beat_n !== base + 2) begin bad++; $display("FAIL basic_count: got %0d want %0d", beat_n - base, 2); end
    total++; if (log_data[base] !== 32'h04030201) begin bad++; $display("FAIL basic_beat0: got %h want 04030201", log_data[base]); end
    total++; if (log_data[base+1] !== 32'h08070605) begin bad++; $display("FAIL basic_beat1: got %h want 08070605", log_data[base+1]); end
    total++; if (log_keep[base] !== 4'hF || log_keep[base+1] !== 4'hF) begin bad++; $display("FAIL basic_keep: got %b %b want 1111", log_keep[base], log_keep[base+1]); end
  endtask

  task automatic test_framing();
    int base;
    do_reset();
    out_ready = 1'b1;
    base = beat_n;
    for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
    wait_beats(base + 4, 40);
    total++; if (beat_n !== base + 4) begin bad++; $display("FAIL frame_count: got %0d want 4", beat_n - base); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (log_last[base+i] !== ((i % 2) == 1)) begin
        bad++; $display("FAIL frame_last%0d: got %b want %b", i, log_last[base+i], ((i % 2) == 1));
      end
    end
    total++; if (log_data[base+3] !== 32'h1F1E1D1C) begin bad++; $display("FAIL frame_beat3: got %h want 1f1e1d1c", log_data[base+3]); end
  endtask

  task automatic test_backpressure();
    int base, p0;
    logic [31:0] held;
    do_reset();
    base = beat_n;
    p0 = pop_cnt;
    for (int i = 0; i < 12; i++) push(8'h20 + 8'(i));
    repeat (10) @(negedge clk_read);
    held = out_data;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid: got %b want 1", out_valid); end
    total++; if (held !== 32'h23222120) begin bad++; $display("FAIL bp_held: got %h want 23222120", held); end
    total++; if (lane_cnt !== 3'd3) begin bad++; $display("FAIL bp_lane: got %0d want 3", lane_cnt); end
    total++; if (pop_cnt - p0 !== 7) begin bad++; $display("FAIL bp_pops: got %0d want 7", pop_cnt - p0); end
    repeat (3) @(negedge clk_read);
    total++; if (out_data !== 32'h23222120 || out_keep !== 4'hF) begin bad++; $display("FAIL bp_stable: got %h %b want 23222120 1111", out_data, out_keep); end
    total++; if (pop_cnt - p0 !== 7) begin bad++; $display("FAIL bp_stalled: got %0d want 7", pop_cnt - p0); end
    out_ready = 1'b1;
    wait_beats(base + 3, 30);
    repeat (4) @(negedge clk_read);
    total++; if (beat_n !== base + 3) begin bad++; $display("FAIL bp_count: got %0d want 3", beat_n - base); end
    total++; if (log_data[base] !== 32'h23222120) begin bad++; $display("FAIL bp_beat0: got %h want 23222120", log_data[base]); end
    total++; if (log_data[base+1] !== 32'h27262524) begin bad++; $display("FAIL bp_beat1: got %h want 27262524", log_data[base+1]); end
    total++; if (log_data[base+2] !== 32'h2B2A2928) begin bad++; $display("FAIL bp_beat2: got %h want 2b2a2928", log_data[base+2]); end
    total++; if (pop_cnt - p0 !== 12) begin bad++; $display("FAIL bp_total_pops: got %0d want 12", pop_cnt - p0); end
  endtask

  task automatic test_flush_partial();
    int base;
    do_reset();
    out_ready = 1'b1;
    base = beat_n;
    for (int i = 0; i < 4; i++) push(8'h30 + 8'(i));
    wait_beats(base + 1, 20);
    push(8'hAA); push(8'hBB); push(8'hCC);
    repeat (5) @(negedge clk_read);
    total++; if (lane_cnt !== 3'd3) begin bad++; $display("FAIL fp_lane: got %0d want 3", lane_cnt); end
    flush = 1'b1;
    @(negedge clk_read);
    flush = 1'b0;
    wait_beats(base + 2, 10);
    total++; if (beat_n !== base + 2) begin bad++; $display("FAIL fp_count: got %0d want 2", beat_n - base); end
    total++; if (log_last[base] !== 1'b0) begin bad++; $display("FAIL fp_first_last: got %b want 0", log_last[base]); end
    total++; if (log_data[base+1] !== 32'h00CCBBAA) begin bad++; $display("FAIL fp_data: got %h want 00ccbbaa", log_data[base+1]); end
    total++; if (log_keep[base+1] !== 4'b0111) begin bad++; $display("FAIL fp_keep: got %b want 0111", log_keep[base+1]); end
    total++; if (log_last[base+1] !== 1'b1) begin bad++; $display("FAIL fp_last: got %b want 1", log_last[base+1]); end
    for (int i = 0; i < 4; i++) push(8'h34 + 8'(i));
    wait_beats(base + 3, 20);
    total++; if (log_keep[base+2] !== 4'hF || log_last[base+2] !== 1'b0) begin bad++; $display("FAIL fp_next: got keep=%b last=%b want 1111 0", log_keep[base+2], log_last[base+2]); end
    for (int i = 0; i < 4; i++) push(8'h38 + 8'(i));
    wait_beats(base + 4, 20);
    total++; if (log_last[base+3] !== 1'b1 || log_data[base+3] !== 32'h3B3A3938) begin bad++; $display("FAIL fp_pkt_end: got %h last=%b want 3b3a3938 1", log_data[base+3], log_last[base+3]); end
  endtask

  task automatic test_flush_empty();
    int base;
    do_reset();
    out_ready = 1'b1;
    base = beat_n;
    for (int i = 0; i < 4; i++) push(8'h40 + 8'(i));
    wait_beats(base + 1, 20);
    repeat (2) @(negedge clk_read);
    flush = 1'b1;
    @(negedge clk_read);
    flush = 1'b0;
    repeat (6) @(negedge clk_read);
    total++; if (beat_n !== base + 1) begin bad++; $display("FAIL fe_no_beat: got %0d want 1", beat_n - base); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fe_valid: got %b want 0", out_valid); end
    for (int i = 0; i < 4; i++) push(8'h44 + 8'(i));
    wait_beats(base + 2, 20);
    total++; if (log_last[base+1] !== 1'b0) begin bad++; $display("FAIL fe_restart: got last=%b want 0", log_last[base+1]); end
  endtask

  task automatic test_flush_with_pop();
    int base;
    do_reset();
    out_ready = 1'b1;
    base = beat_n;
    push(8'h50); push(8'h51); push(8'h52);
    repeat (5) @(negedge clk_read);
    push(8'h53);
    flush = 1'b1;
    @(negedge clk_read);
    flush = 1'b0;
    wait_beats(base + 1, 10);
    repeat (6) @(negedge clk_read);
    total++; if (beat_n !== base + 1) begin bad++; $display("FAIL fw_count: got %0d want 1", beat_n - base); end
    total++; if (log_data[base] !== 32'h53525150) begin bad++; $display("FAIL fw_data: got %h want 53525150", log_data[base]); end
    total++; if (log_keep[base] !== 4'hF || log_last[base] !== 1'b1) begin bad++; $display("FAIL fw_frame: got keep=%b last=%b want 1111 1", log_keep[base], log_last[base]); end
    for (int i = 0; i < 4; i++) push(8'h54 + 8'(i));
    wait_beats(base + 2, 20);
    total++; if (log_last[base+1] !== 1'b0) begin bad++; $display("FAIL fw_restart: got last=%b want 0", log_last[base+1]); end
  endtask

  task automatic test_async_reset();
    int base;
    do_reset();
    for (int i = 0; i < 6; i++) push(8'h60 + 8'(i));
    repeat (10) @(negedge clk_read);
    total++; if (out_valid !== 1'b1 || lane_cnt !== 3'd2) begin bad++; $display("FAIL ar_setup: got valid=%b lane=%0d want 1 2", out_valid, lane_cnt); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || out_last !== 1'b0) begin bad++; $display("FAIL ar_valid_last: got %b %b want 0 0", out_valid, out_last); end
    total++; if (out_data !== 32'h0 || out_keep !== 4'h0) begin bad++; $display("FAIL ar_data_keep: got %h %b want 0 0", out_data, out_keep); end
    total++; if (lane_cnt !== 3'd0) begin bad++; $display("FAIL ar_lane: got %0d want 0", lane_cnt); end
    @(negedge clk_read);
    rst_n = 1'b1;
    out_ready = 1'b1;
    base = beat_n;
    for (int i = 0; i < 4; i++) push(8'h66 + 8'(i));
    wait_beats(base + 1, 20);
    repeat (3) @(negedge clk_read);
    total++; if (beat_n !== base + 1) begin bad++; $display("FAIL ar_count: got %0d want 1", beat_n - base); end
    total++; if (log_data[base] !== 32'h69686766 || log_keep[base] !== 4'hF) begin bad++; $display("FAIL ar_clean: got %h %b want 69686766 1111", log_data[base], log_keep[base]); end
  endtask

  task automatic test_no_empty_read();
    total++; if (bad_read !== 0) begin bad++; $display("FAIL empty_read: got %0d want 0", bad_read); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_framing();
    test_backpressure();
    test_flush_partial();
    test_flush_empty();
    test_flush_with_pop();
    test_async_reset();
    test_no_empty_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
